// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared packed-BCD constants, digit type and serial FSM states
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_RADIX   = 10;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// rtl/bcd_serial_subtractor_if.sv - start/busy/done handshake and operand/result bus
interface bcd_serial_subtractor_if #(
  parameter int NDIGITS = 4
);
  localparam int W = 4 * NDIGITS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         err;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, err
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, err
  );

endinterface

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - one-digit BCD subtract with borrow, flags non-BCD inputs
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout,
  output logic       bad
);

  // 5-bit two's complement covers -16..15, the full span of any nibble pair
  logic [4:0] t;

  always_comb begin
    t    = {1'b0, a_d} - {1'b0, b_d} - {4'b0000, bin};
    bout = t[4];
    d    = bout ? 4'(t[3:0] + 4'(BCD_RADIX)) : t[3:0];
    bad  = (a_d > 4'(BCD_MAX)) || (b_d > 4'(BCD_MAX));
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// rtl/bcd_serial_subtractor.sv - digit-serial packed-BCD A-B-BIN, LSD first, one digit per clock
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_serial_subtractor_if.slave  bus
);

  localparam int W  = BCD_DIGIT_W * NDIGITS;
  localparam int CW = $clog2(NDIGITS) + 1;

  bcd_state_e   state_q, state_d;
  logic [W-1:0] opa_q, opa_d;
  logic [W-1:0] opb_q, opb_d;
  logic [W-1:0] res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         borrow_q, borrow_d;
  logic         err_acc_q, err_acc_d;
  logic [W-1:0] diff_q, diff_d;
  logic         bout_q, bout_d;
  logic         err_q, err_d;

  bcd_digit_t   dig;
  logic         dig_bout;
  logic         dig_bad;
  logic         err_now;

  bcd_digit_sub u_digit_sub (
    .a_d  (opa_q[BCD_DIGIT_W-1:0]),
    .b_d  (opb_q[BCD_DIGIT_W-1:0]),
    .bin  (borrow_q),
    .d    (dig),
    .bout (dig_bout),
    .bad  (dig_bad)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    err_acc_d = err_acc_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    err_d     = err_q;
    err_now   = err_acc_q | dig_bad;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = RUN;
          opa_d     = bus.a;
          opb_d     = bus.b;
          borrow_d  = bus.bin;
          cnt_d     = '0;
          err_acc_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // operands shift down so the active digit is always the low nibble;
        // results enter at the top and land in position k after NDIGITS shifts
        opa_d     = opa_q >> BCD_DIGIT_W;
        opb_d     = opb_q >> BCD_DIGIT_W;
        res_d     = W'({dig, res_q} >> BCD_DIGIT_W);
        borrow_d  = dig_bout;
        err_acc_d = err_now;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIGITS - 1)) begin
          state_d = DONE;
          err_d   = err_now;
          diff_d  = err_now ? '0 : res_d;
          bout_d  = err_now ? 1'b0 : dig_bout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      err_acc_q <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      err_acc_q <= err_acc_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb/tb_bcd_serial_subtractor.sv - randomized and directed checks against a decimal reference model
module tb_bcd_serial_subtractor;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bcd_serial_subtractor_if #(.NDIGITS(ND)) bus ();

  bcd_serial_subtractor #(.NDIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // decimal arithmetic on the values the packed digits represent
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic bo, output logic er);
    int ai, bi, r, nib;
    ai = 0; bi = 0; er = 1'b0;
    for (int i = ND - 1; i >= 0; i--) begin
      nib = int'((a >> (4 * i)) & 16'hF);
      if (nib > 9) er = 1'b1;
      ai = ai * 10 + nib;
      nib = int'((b >> (4 * i)) & 16'hF);
      if (nib > 9) er = 1'b1;
      bi = bi * 10 + nib;
    end
    r  = ai - bi - int'(bin);
    bo = (r < 0);
    if (bo) r = r + 10000;
    d = '0;
    for (int i = 0; i < ND; i++) begin
      d = d | (16'(r % 10) << (4 * i));
      r = r / 10;
    end
    if (er) begin
      d  = '0;
      bo = 1'b0;
    end
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < ND; i++) v = v | (16'($urandom_range(0, 9)) << (4 * i));
    return v;
  endfunction

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [15:0] ed;
    logic eb, ee;
    model(a, b, bin, ed, eb, ee);
    check({tag, ".diff"}, 32'(bus.diff), 32'(ed));
    check({tag, ".bout"}, 32'(bus.bout), 32'(eb));
    check({tag, ".err"},  32'(bus.err),  32'(ee));
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin);
    int nbusy;
    logic seen;
    nbusy = 0;
    seen  = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) nbusy++;
    end
    check({tag, ".done"}, 32'(seen), 32'd1);
    check({tag, ".busy_cycles"}, 32'(nbusy), ND);
    check_result(tag, a, b, bin);
  endtask

  initial begin
    logic [15:0] qa[$], qb[$];
    logic        qbin[$];
    logic [15:0] ra, rb;
    logic        rbin;
    int          last_done, cyc, ndone;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    check("rst.diff", 32'(bus.diff), 0);
    check("rst.bout", 32'(bus.bout), 0);
    check("rst.err",  32'(bus.err),  0);
    rst_n = 1'b1;

    run_op("basic",    16'h5432, 16'h1234, 1'b0);
    check("basic.lit", 32'(bus.diff), 32'h4198);
    run_op("neg1",     16'h0000, 16'h0001, 1'b0);
    check("neg1.lit",  32'(bus.diff), 32'h9999);
    run_op("zbin",     16'h0000, 16'h0000, 1'b1);
    check("zbin.bout", 32'(bus.bout), 1);
    run_op("ripple",   16'h1000, 16'h0001, 1'b0);
    check("ripple.lit", 32'(bus.diff), 32'h0999);
    run_op("equal",    16'h9999, 16'h9999, 1'b0);
    run_op("baddigit", 16'h12A4, 16'h0001, 1'b0);
    check("baddigit.err", 32'(bus.err), 1);
    run_op("clear",    16'h0042, 16'h0017, 1'b1);

    for (int n = 0; n < 24; n++) begin
      ra = rand_bcd(); rb = rand_bcd(); rbin = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ra[4 * $urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      run_op("rand", ra, rb, rbin);
    end

    // start held high: back-to-back ops, operands only matter at accept edges
    @(negedge clk);
    ra = rand_bcd(); rb = rand_bcd(); rbin = 1'($urandom);
    bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.bin = rbin;
    qa.push_back(ra); qb.push_back(rb); qbin.push_back(rbin);
    last_done = -1; ndone = 0;
    for (cyc = 0; cyc < 60 && ndone < 6; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        check_result("b2b", qa.pop_front(), qb.pop_front(), qbin.pop_front());
        if (last_done >= 0) check("b2b.period", 32'(cyc - last_done), ND + 1);
        last_done = cyc;
        ndone++;
        ra = rand_bcd(); rb = rand_bcd(); rbin = 1'($urandom);
        bus.a = ra; bus.b = rb; bus.bin = rbin;
        qa.push_back(ra); qb.push_back(rb); qbin.push_back(rbin);
      end else begin
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom);
      end
    end
    check("b2b.count", 32'(ndone), 6);
    bus.start = 1'b0;
    repeat (ND + 3) @(negedge clk);

    // reset during the second RUN cycle aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h8765; bus.b = 16'h1111; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort.busy1", 32'(bus.busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort.busy", 32'(bus.busy), 0);
    check("abort.diff", 32'(bus.diff), 0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort.no_done", 32'(ndone), 0);
    run_op("after_rst", 16'h2500, 16'h0499, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
